m2_block_scheduler: RTL and testbench

Top-level sequencer for the Milestone 2 inverse-transform datapath. It walks every 8x8 block of the Y, U and V planes in order, and issues start pulses to the fetch-S (FS), compute-T (CT), compute-S (CS) and write-S (WS) units. FS of one block overlaps CS of the previous block, and WS overlaps CT. It generates per-block SRAM base addresses and multiplexes the single SRAM port between FS (read) and WS (write).

---
 rtl/m2_block_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_m2_block_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2_block_scheduler.sv
// Milestone 2 block sequencer: walks every 8x8 block of Y, U, V, overlaps FS/CS and CT/WS,
// generates per-block base addresses and shares the SRAM port between FS reads and WS writes.
module m2_block_scheduler #(
    parameter int unsigned Y_COLS     = 40,
    parameter int unsigned UV_COLS    = 20,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned PRE_Y_BASE = 76800,
    parameter int unsigned PRE_U_BASE = 153600,
    parameter int unsigned PRE_V_BASE = 192000,
    parameter int unsigned OUT_Y_BASE = 0,
    parameter int unsigned OUT_U_BASE = 38400,
    parameter int unsigned OUT_V_BASE = 57600
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        M2_start,
    output logic        M2_done,
    output logic        fs_start,
    output logic        ct_start,
    output logic        cs_start,
    output logic        ws_start,
    input  logic        fs_done,
    input  logic        ct_done,
    input  logic        cs_done,
    input  logic        ws_done,
    output logic [17:0] fs_base,
    output logic [17:0] ws_base,
    input  logic [17:0] fs_sram_address,
    input  logic [17:0] ws_sram_address,
    input  logic [15:0] ws_sram_write_data,
    input  logic        ws_sram_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_FS, S_LEAD_CT, S_MEGA_A, S_MEGA_B, S_LEAD_CS, S_LEAD_WS, S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] plane;
        logic [4:0] rb;
        logic [5:0] cb;
    } coord_t;

    localparam logic [1:0] P_Y = 2'd0;
    localparam logic [1:0] P_U = 2'd1;
    localparam logic [1:0] P_V = 2'd2;
    localparam coord_t LAST_BLOCK = '{plane: P_V, rb: 5'(ROWS - 1), cb: 6'(UV_COLS - 1)};

    function automatic logic [5:0] col_last(input logic [1:0] plane);
        return (plane == P_Y) ? 6'(Y_COLS - 1) : 6'(UV_COLS - 1);
    endfunction

    // Column fastest, then row, then plane; wraps V back to Y for the next frame.
    function automatic coord_t next_pos(input coord_t c);
        coord_t n;
        n = c;
        if (c.cb != col_last(c.plane)) begin
            n.cb = c.cb + 6'd1;
        end else begin
            n.cb = '0;
            if (c.rb != 5'(ROWS - 1)) begin
                n.rb = c.rb + 5'd1;
            end else begin
                n.rb    = '0;
                n.plane = (c.plane == P_V) ? P_Y : c.plane + 2'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [17:0] fs_addr(input coord_t c);
        logic [17:0] row, col, base;
        row = 18'(c.rb);
        col = 18'(c.cb);
        case (c.plane)
            P_Y:     base = 18'(PRE_Y_BASE) + (row << 11) + (row << 9);
            P_U:     base = 18'(PRE_U_BASE) + (row << 10) + (row << 8);
            default: base = 18'(PRE_V_BASE) + (row << 10) + (row << 8);
        endcase
        return base + (col << 3);
    endfunction

    function automatic logic [17:0] ws_addr(input coord_t c);
        logic [17:0] row, col, base;
        row = 18'(c.rb);
        col = 18'(c.cb);
        case (c.plane)
            P_Y:     base = 18'(OUT_Y_BASE) + (row << 10) + (row << 8);
            P_U:     base = 18'(OUT_U_BASE) + (row << 9) + (row << 7);
            default: base = 18'(OUT_V_BASE) + (row << 9) + (row << 7);
        endcase
        return base + (col << 2);
    endfunction

    state_t r_state, w_state_nxt;
    coord_t r_fs_pos, r_ws_pos, w_fs_pos_nxt, w_ws_pos_nxt;
    logic   r_fetch_exhausted;
    logic   r_fs_flag, r_ct_flag, r_cs_flag, r_ws_flag;
    logic   r_fs_start, r_ct_start, r_cs_start, r_ws_start, r_m2_done;
    logic   w_fs_start, w_ct_start, w_cs_start, w_ws_start, w_m2_done;
    logic   w_fs_acc, w_ct_acc, w_cs_acc, w_ws_acc;
    logic   w_leave;
    logic [17:0] r_fs_base, r_ws_base;

    // A done counts only while its unit is owned by the state and not in its start cycle.
    assign w_fs_acc = fs_done & ~r_fs_start & (r_state == S_LEAD_FS || r_state == S_MEGA_A);
    assign w_ct_acc = ct_done & ~r_ct_start & (r_state == S_LEAD_CT || r_state == S_MEGA_B);
    assign w_cs_acc = cs_done & ~r_cs_start & (r_state == S_MEGA_A  || r_state == S_LEAD_CS);
    assign w_ws_acc = ws_done & ~r_ws_start & (r_state == S_MEGA_B  || r_state == S_LEAD_WS);

    assign w_fs_pos_nxt = w_fs_acc ? next_pos(r_fs_pos) : r_fs_pos;
    assign w_ws_pos_nxt = w_ws_acc ? next_pos(r_ws_pos) : r_ws_pos;

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fs_start  = 1'b0;
        w_ct_start  = 1'b0;
        w_cs_start  = 1'b0;
        w_ws_start  = 1'b0;
        w_m2_done   = 1'b0;
        w_leave     = 1'b0;
        case (r_state)
            S_IDLE: if (M2_start) begin
                w_state_nxt = S_LEAD_FS;
                w_fs_start  = 1'b1;
            end
            S_LEAD_FS: if (w_fs_acc) begin
                w_state_nxt = S_LEAD_CT;
                w_ct_start  = 1'b1;
            end
            S_LEAD_CT: if (w_ct_acc) begin
                w_state_nxt = S_MEGA_A;
                w_cs_start  = 1'b1;
                w_fs_start  = 1'b1;
            end
            S_MEGA_A: if ((r_cs_flag | w_cs_acc) && (r_fs_flag | w_fs_acc)) begin
                w_state_nxt = S_MEGA_B;
                w_ct_start  = 1'b1;
                w_ws_start  = 1'b1;
            end
            S_MEGA_B: begin
                w_leave = (r_ct_flag | w_ct_acc) && (r_ws_flag | w_ws_acc);
                if (w_leave) begin
                    w_cs_start = 1'b1;
                    if (r_fetch_exhausted) begin
                        w_state_nxt = S_LEAD_CS;
                    end else begin
                        w_state_nxt = S_MEGA_A;
                        w_fs_start  = 1'b1;
                    end
                end
            end
            S_LEAD_CS: if (w_cs_acc) begin
                w_state_nxt = S_LEAD_WS;
                w_ws_start  = 1'b1;
            end
            S_LEAD_WS: if (w_ws_acc) begin
                w_state_nxt = S_DONE;
                w_m2_done   = 1'b1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_fs_start        <= 1'b0;
            r_ct_start        <= 1'b0;
            r_cs_start        <= 1'b0;
            r_ws_start        <= 1'b0;
            r_m2_done         <= 1'b0;
            r_fs_flag         <= 1'b0;
            r_ct_flag         <= 1'b0;
            r_cs_flag         <= 1'b0;
            r_ws_flag         <= 1'b0;
            r_fetch_exhausted <= 1'b0;
            r_fs_pos          <= '0;
            r_ws_pos          <= '0;
            r_fs_base         <= 18'(PRE_Y_BASE);
            r_ws_base         <= 18'(OUT_Y_BASE);
        end else begin
            r_fs_start <= w_fs_start;
            r_ct_start <= w_ct_start;
            r_cs_start <= w_cs_start;
            r_ws_start <= w_ws_start;
            r_m2_done  <= w_m2_done;
            if (w_state_nxt != r_state) begin
                r_fs_flag <= 1'b0;
                r_ct_flag <= 1'b0;
                r_cs_flag <= 1'b0;
                r_ws_flag <= 1'b0;
            end else begin
                r_fs_flag <= r_fs_flag | w_fs_acc;
                r_ct_flag <= r_ct_flag | w_ct_acc;
                r_cs_flag <= r_cs_flag | w_cs_acc;
                r_ws_flag <= r_ws_flag | w_ws_acc;
            end
            if (r_state == S_IDLE) begin
                r_fetch_exhausted <= 1'b0;
            end else if (w_fs_acc && r_fs_pos == LAST_BLOCK) begin
                r_fetch_exhausted <= 1'b1;
            end
            r_fs_pos <= w_fs_pos_nxt;
            r_ws_pos <= w_ws_pos_nxt;
            // Bases load from the advanced coordinates so they are settled before the next start.
            r_fs_base <= fs_addr(w_fs_pos_nxt);
            r_ws_base <= ws_addr(w_ws_pos_nxt);
        end
    end

    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (r_state)
            S_LEAD_FS, S_MEGA_A: SRAM_address = fs_sram_address;
            S_MEGA_B, S_LEAD_WS: begin
                SRAM_address    = ws_sram_address;
                SRAM_write_data = ws_sram_write_data;
                SRAM_we_n       = ws_sram_we_n;
            end
            default: ;
        endcase
    end

    assign fs_start = r_fs_start;
    assign ct_start = r_ct_start;
    assign cs_start = r_cs_start;
    assign ws_start = r_ws_start;
    assign M2_done  = r_m2_done;
    assign fs_base  = r_fs_base;
    assign ws_base  = r_ws_base;

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Scoreboard bench for m2_block_scheduler: directed phase/mux/reset scenarios plus a
// full frame driven by randomly delayed unit models, checked against a plane-walk model.
module tb_m2_block_scheduler;

    logic        CLOCK_50_I = 1'b0;
    logic        Resetn = 1'b0;
    logic        M2_start = 1'b0;
    logic        M2_done;
    logic        fs_start, ct_start, cs_start, ws_start;
    logic        fs_done, ct_done, cs_done, ws_done;
    logic [17:0] fs_base, ws_base;
    logic [17:0] fs_sram_address = '0;
    logic [17:0] ws_sram_address = '0;
    logic [15:0] ws_sram_write_data = '0;
    logic        ws_sram_we_n = 1'b1;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    logic [3:0]  dir_done = 4'b0;
    logic [3:0]  auto_done;
    logic [3:0]  starts;
    logic        auto_mode = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    int          fs_cnt = 0;
    int          ws_cnt = 0;
    int          done_cnt = 0;
    logic [17:0] fs_held = '0;
    logic [17:0] ws_held = '0;
    logic [17:0] last_ws_base = '0;
    int unsigned exp_fs[$];
    int unsigned exp_ws[$];

    assign starts  = {ws_start, cs_start, ct_start, fs_start};
    assign fs_done = auto_done[0] | dir_done[0];
    assign ct_done = auto_done[1] | dir_done[1];
    assign cs_done = auto_done[2] | dir_done[2];
    assign ws_done = auto_done[3] | dir_done[3];

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    m2_block_scheduler dut (
        .CLOCK_50_I         (CLOCK_50_I),
        .Resetn             (Resetn),
        .M2_start           (M2_start),
        .M2_done            (M2_done),
        .fs_start           (fs_start),
        .ct_start           (ct_start),
        .cs_start           (cs_start),
        .ws_start           (ws_start),
        .fs_done            (fs_done),
        .ct_done            (ct_done),
        .cs_done            (cs_done),
        .ws_done            (ws_done),
        .fs_base            (fs_base),
        .ws_base            (ws_base),
        .fs_sram_address    (fs_sram_address),
        .ws_sram_address    (ws_sram_address),
        .ws_sram_write_data (ws_sram_write_data),
        .ws_sram_we_n       (ws_sram_we_n),
        .SRAM_address       (SRAM_address),
        .SRAM_write_data    (SRAM_write_data),
        .SRAM_we_n          (SRAM_we_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50_I);
        #1;
    endtask

    // Reference walk: plane by plane, row by row, column by column; a block row spans
    // 8 lines of the plane width (one sample per pre-IDCT word, two pixels per output word).
    task automatic start_frame();
        int unsigned pre_base[3];
        int unsigned out_base[3];
        int unsigned cols;
        pre_base = '{76800, 153600, 192000};
        out_base = '{0, 38400, 57600};
        exp_fs.delete();
        exp_ws.delete();
        fs_cnt = 0;
        ws_cnt = 0;
        done_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            cols = (p == 0) ? 40 : 20;
            for (int r = 0; r < 30; r++) begin
                for (int c = 0; c < int'(cols); c++) begin
                    exp_fs.push_back(pre_base[p] + r * (cols * 8 * 8) + c * 8);
                    exp_ws.push_back(out_base[p] + r * (cols * 8 * 4) + c * 4);
                end
            end
        end
        M2_start = 1'b1;
        tick();
        M2_start = 1'b0;
    endtask

    task automatic phase(input int first, input int second, input int gap,
                         input logic [3:0] exp_starts, input string name);
        tick();
        dir_done = 4'b0;
        dir_done[first] = 1'b1;
        for (int i = 0; i < gap; i++) begin
            tick();
            dir_done = 4'b0;
            chk({name, "_hold"}, 32'(starts), 32'd0);
        end
        dir_done[second] = 1'b1;
        tick();
        dir_done = 4'b0;
        chk({name, "_go"}, 32'(starts), 32'(exp_starts));
    endtask

    for (genvar u = 0; u < 4; u++) begin : g_unit
        logic done_r = 1'b0;
        assign auto_done[u] = done_r;
        initial begin
            forever begin
                @(posedge CLOCK_50_I);
                #1;
                done_r = 1'b0;
                if (auto_mode && starts[u]) begin
                    repeat ($urandom_range(8, 1)) @(posedge CLOCK_50_I);
                    #1;
                    done_r = 1'b1;
                end
            end
        end
    end

    initial begin
        int unsigned e;
        forever begin
            @(negedge CLOCK_50_I);
            if (Resetn) begin
                if (fs_start) begin
                    fs_cnt++;
                    fs_held = fs_base;
                    if (exp_fs.size() == 0) begin
                        chk("fs_sb_underflow", 32'(exp_fs.size()), 32'd1);
                    end else begin
                        e = exp_fs.pop_front();
                        chk("fs_base_sb", 32'(fs_base), e);
                    end
                    if (fs_cnt == 1201) chk("fs_base_first_U", 32'(fs_base), 32'd153600);
                end
                if (ws_start) begin
                    ws_cnt++;
                    ws_held = ws_base;
                    last_ws_base = ws_base;
                    if (exp_ws.size() == 0) begin
                        chk("ws_sb_underflow", 32'(exp_ws.size()), 32'd1);
                    end else begin
                        e = exp_ws.pop_front();
                        chk("ws_base_sb", 32'(ws_base), e);
                    end
                    if (ws_cnt == 1801) chk("ws_base_first_V", 32'(ws_base), 32'd57600);
                end
                if (M2_done) done_cnt++;
                if (auto_mode && fs_done) chk("fs_base_stable", 32'(fs_base), 32'(fs_held));
                if (auto_mode && ws_done) chk("ws_base_stable", 32'(ws_base), 32'(ws_held));
            end
        end
    end

    initial begin
        int cyc;
        fs_sram_address = 18'h0_1111;
        ws_sram_address = 18'h2_2222;
        ws_sram_write_data = 16'h3333;
        ws_sram_we_n = 1'b0;
        repeat (3) tick();
        chk("rst_starts", 32'(starts), 32'd0);
        chk("rst_m2_done", 32'(M2_done), 32'd0);
        chk("rst_fs_base", 32'(fs_base), 32'd76800);
        chk("rst_ws_base", 32'(ws_base), 32'd0);
        chk("rst_sram_addr", 32'(SRAM_address), 32'd0);
        chk("rst_sram_we_n", 32'(SRAM_we_n), 32'd1);
        Resetn = 1'b1;
        tick();
        chk("idle_sram_data", 32'(SRAM_write_data), 32'd0);

        start_frame();
        chk("first_fs_start", 32'(starts), 32'b0001);
        chk("first_fs_base", 32'(fs_base), 32'd76800);
        chk("lead_fs_addr", 32'(SRAM_address), 32'h0_1111);
        chk("lead_fs_we_n", 32'(SRAM_we_n), 32'd1);
        dir_done = 4'b0011;
        tick();
        dir_done = 4'b0;
        chk("ignore_same_cycle_done", 32'(starts), 32'd0);

        phase(0, 0, 0, 4'b0010, "lead_fs");
        phase(1, 1, 0, 4'b0101, "lead_ct");
        chk("second_fs_base", 32'(fs_base), 32'd76808);
        M2_start = 1'b1;
        fs_sram_address = 18'h0_4567;
        ws_sram_address = 18'h1_7654;
        ws_sram_write_data = 16'hBEEF;
        ws_sram_we_n = 1'b0;
        #1;
        chk("mega_a_we_n", 32'(SRAM_we_n), 32'd1);
        chk("mega_a_addr", 32'(SRAM_address), 32'h0_4567);
        chk("mega_a_data", 32'(SRAM_write_data), 32'd0);
        tick();
        M2_start = 1'b0;
        chk("m2_start_busy", 32'(starts), 32'd0);

        phase(2, 0, 3, 4'b1010, "mega_a_cs_first");
        chk("first_ws_base", 32'(ws_base), 32'd0);
        ws_sram_address = 18'(20'h2_ABCD);
        ws_sram_write_data = 16'h5A5A;
        #1;
        chk("mega_b_addr", 32'(SRAM_address), 32'h2_ABCD);
        chk("mega_b_data", 32'(SRAM_write_data), 32'h5A5A);
        chk("mega_b_we_n", 32'(SRAM_we_n), 32'd0);

        phase(3, 1, 5, 4'b0101, "mega_b_ws_first");
        phase(0, 2, 0, 4'b1010, "mega_a_same");
        phase(1, 3, 0, 4'b0101, "mega_b_same");
        phase(2, 0, 2, 4'b1010, "mega_a_cs_first2");
        phase(1, 3, 4, 4'b0101, "mega_b_ct_first");
        phase(0, 2, 1, 4'b1010, "mega_a_fs_first");

        tick();
        ws_sram_we_n = 1'b0;
        Resetn = 1'b0;
        #1;
        chk("midrst_starts", 32'(starts), 32'd0);
        chk("midrst_m2_done", 32'(M2_done), 32'd0);
        chk("midrst_fs_base", 32'(fs_base), 32'd76800);
        chk("midrst_ws_base", 32'(ws_base), 32'd0);
        chk("midrst_sram_addr", 32'(SRAM_address), 32'd0);
        chk("midrst_sram_data", 32'(SRAM_write_data), 32'd0);
        chk("midrst_sram_we_n", 32'(SRAM_we_n), 32'd1);
        tick();
        Resetn = 1'b1;
        repeat (2) tick();

        auto_mode = 1'b1;
        start_frame();
        cyc = 0;
        while (M2_done !== 1'b1 && cyc < 70000) begin
            tick();
            cyc++;
        end
        chk("m2_done_seen", 32'(M2_done), 32'd1);
        tick();
        chk("m2_done_one_cycle", 32'(M2_done), 32'd0);
        auto_mode = 1'b0;
        repeat (3) tick();
        chk("frame_fs_starts", 32'(fs_cnt), 32'd2400);
        chk("frame_ws_starts", 32'(ws_cnt), 32'd2400);
        chk("frame_m2_done_cnt", 32'(done_cnt), 32'd1);
        chk("frame_last_ws_base", 32'(last_ws_base), 32'd76236);
        chk("frame_fs_sb_left", 32'(exp_fs.size()), 32'd0);
        chk("frame_ws_sb_left", 32'(exp_ws.size()), 32'd0);
        chk("idle_after_frame_we_n", 32'(SRAM_we_n), 32'd1);
        chk("idle_after_frame_starts", 32'(starts), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
